// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops registered with one-cycle latency, plus iterative MUL/DIVU/REMU.
// Define SEQ_ALU_SIGNED_DIV_EN to add signed DIV (op 16) and REM (op 17).
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_src0,
    input  logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_res,
    output logic             alu_res_valid
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);
    localparam logic [4:0] OP_MUL  = 5'd13;
    localparam logic [4:0] OP_DIVU = 5'd14;
    localparam logic [4:0] OP_REMU = 5'd15;
    localparam logic [4:0] OP_REM  = 5'd17;
`ifdef SEQ_ALU_SIGNED_DIV_EN
    localparam logic [4:0] OP_DIV  = 5'd16;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t           state_r;
    logic [SW-1:0]    cnt_r;
    logic [WIDTH-1:0] opa_r, opb_r, acc_r;
    logic             rem_sel_r, neg_q_r, neg_r_r;

    logic             is_mul_s, is_div_s, is_rem_s, is_sgn_s;
    logic [WIDTH-1:0] mag0_s, mag1_s, mul_acc_s, rem_next_s, quo_next_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s, div_res_s;
    logic [WIDTH:0]   sub_s;
    logic             q_bit_s;

    function automatic logic [WIDTH-1:0] single_op(input logic [4:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = ($signed(a) < $signed(b)) ? ONE : ZERO;
            5'd3:    r = (a < b) ? ONE : ZERO;
            5'd4:    r = a & b;
            5'd5:    r = a | b;
            5'd6:    r = a ^ b;
            5'd7:    r = ~(a | b);
            5'd8:    r = a << b[SW-1:0];
            5'd9:    r = a >> b[SW-1:0];
            5'd10:   r = $signed(a) >>> b[SW-1:0];
            5'd11:   r = a;
            5'd12:   r = b;
            default: r = ZERO;
        endcase
        return r;
    endfunction

    assign alu_ready = (state_r == IDLE);

    // Request decode and operand magnitudes for the divider
    always_comb begin
        is_mul_s = (alu_op == OP_MUL);
        is_div_s = (alu_op == OP_DIVU) || (alu_op == OP_REMU);
        is_sgn_s = 1'b0;
`ifdef SEQ_ALU_SIGNED_DIV_EN
        if ((alu_op == OP_DIV) || (alu_op == OP_REM)) begin
            is_div_s = 1'b1;
            is_sgn_s = 1'b1;
        end else begin
            is_sgn_s = 1'b0;
        end
`endif
        is_rem_s = (alu_op == OP_REMU) || (is_sgn_s && (alu_op == OP_REM));
        mag0_s = (is_sgn_s && alu_src0[WIDTH-1]) ? (ZERO - alu_src0) : alu_src0;
        mag1_s = (is_sgn_s && alu_src1[WIDTH-1]) ? (ZERO - alu_src1) : alu_src1;
    end

    // One shift-add step and one restoring-division step; a zero divisor yields all-ones / dividend
    always_comb begin
        mul_acc_s  = acc_r + (opb_r[0] ? opa_r : ZERO);
        sub_s      = {acc_r, opa_r[WIDTH-1]} - {1'b0, opb_r};
        q_bit_s    = ~sub_s[WIDTH];
        rem_next_s = q_bit_s ? sub_s[WIDTH-1:0] : {acc_r[WIDTH-2:0], opa_r[WIDTH-1]};
        quo_next_s = {opa_r[WIDTH-2:0], q_bit_s};
        quo_fix_s  = neg_q_r ? (ZERO - quo_next_s) : quo_next_s;
        rem_fix_s  = neg_r_r ? (ZERO - rem_next_s) : rem_next_s;
        div_res_s  = rem_sel_r ? rem_fix_s : quo_fix_s;
    end

    // Control FSM, iteration datapath and registered result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= IDLE;
            cnt_r         <= {SW{1'b0}};
            opa_r         <= ZERO;
            opb_r         <= ZERO;
            acc_r         <= ZERO;
            rem_sel_r     <= 1'b0;
            neg_q_r       <= 1'b0;
            neg_r_r       <= 1'b0;
            alu_res       <= ZERO;
            alu_res_valid <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    alu_res_valid <= 1'b0;
                    cnt_r         <= {SW{1'b0}};
                    acc_r         <= ZERO;
                    if (alu_valid && is_mul_s) begin
                        opa_r   <= alu_src0;
                        opb_r   <= alu_src1;
                        state_r <= MUL;
                    end else if (alu_valid && is_div_s) begin
                        opa_r     <= mag0_s;
                        opb_r     <= mag1_s;
                        rem_sel_r <= is_rem_s;
                        neg_q_r   <= is_sgn_s && (alu_src0[WIDTH-1] ^ alu_src1[WIDTH-1])
                                     && (alu_src1 != ZERO);
                        neg_r_r   <= is_sgn_s && alu_src0[WIDTH-1];
                        state_r   <= DIV;
                    end else if (alu_valid) begin
                        alu_res       <= single_op(alu_op, alu_src0, alu_src1);
                        alu_res_valid <= 1'b1;
                    end else begin
                        alu_res_valid <= 1'b0;
                    end
                end
                MUL: begin
                    acc_r <= mul_acc_s;
                    opa_r <= opa_r << 1;
                    opb_r <= opb_r >> 1;
                    cnt_r <= cnt_r + SW'(1);
                    if (cnt_r == CNT_LAST) begin
                        alu_res       <= mul_acc_s;
                        alu_res_valid <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        alu_res_valid <= 1'b0;
                    end
                end
                DIV: begin
                    acc_r <= rem_next_s;
                    opa_r <= quo_next_s;
                    cnt_r <= cnt_r + SW'(1);
                    if (cnt_r == CNT_LAST) begin
                        alu_res       <= div_res_s;
                        alu_res_valid <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        alu_res_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    alu_res_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); honours SEQ_ALU_SIGNED_DIV_EN.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_op = 5'd0;
    logic [31:0] alu_src0 = 32'd0;
    logic [31:0] alu_src1 = 32'd0;
    logic [31:0] alu_res;
    logic        alu_res_valid;
    int checks = 0;
    int failures = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_op(alu_op), .alu_src0(alu_src0), .alu_src1(alu_src1),
        .alu_res(alu_res), .alu_res_valid(alu_res_valid)
    );

    always #5 clk = ~clk;

    // Drives one request at a negedge; returns result and the negedge count at which valid appeared (-1 on timeout)
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int n);
        bit found = 1'b0;
        alu_valid = 1'b1; alu_op = op; alu_src0 = a; alu_src1 = b;
        res = 32'd0; n = -1;
        @(negedge clk);
        alu_valid = 1'b0; alu_src0 = ~a; alu_src1 = ~b;
        for (int i = 1; i <= 100; i++) begin
            if (!found && alu_res_valid) begin
                found = 1'b1; res = alu_res; n = i;
            end
            if (!found) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (alu_ready !== 1'b1 || alu_res !== 32'd0 || alu_res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ready=%b res=%h valid=%b want 1/00000000/0", alu_ready, alu_res, alu_res_valid);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_sweep();
        logic [31:0] exp_tab [13];
        exp_tab = '{32'h80010000, 32'h8000FFFE, 32'h00000001, 32'h00000000, 32'h00000001,
                    32'h8000FFFF, 32'h8000FFFE, 32'h7FFF0000, 32'h0001FFFE, 32'h40007FFF,
                    32'hC0007FFF, 32'h8000FFFF, 32'h00000001};
        alu_valid = 1'b1; alu_src0 = 32'h8000FFFF; alu_src1 = 32'h00000001; alu_op = 5'd0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            checks++;
            if (alu_res_valid !== 1'b1 || alu_ready !== 1'b1 || alu_res !== exp_tab[i]) begin
                failures++;
                $display("FAIL sweep_op%0d: res=%h valid=%b ready=%b want %h/1/1", i, alu_res, alu_res_valid, alu_ready, exp_tab[i]);
            end
            if (i < 12) alu_op = 5'(i + 1);
            else alu_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (alu_res_valid !== 1'b0) begin
            failures++;
            $display("FAIL sweep_idle_valid: valid=%b want 0", alu_res_valid);
        end
    endtask

    task automatic test_mul_busy();
        int busy = 0;
        int pulses = 0;
        alu_valid = 1'b1; alu_op = 5'd13; alu_src0 = 32'h12345678; alu_src1 = 32'h00000010;
        @(negedge clk);
        alu_op = 5'd0; alu_src0 = 32'd2; alu_src1 = 32'd3;
        for (int i = 0; i < 32; i++) begin
            if (!alu_ready) busy++;
            if (alu_res_valid) pulses++;
            @(negedge clk);
        end
        checks++;
        if (busy != 32 || pulses != 0) begin
            failures++;
            $display("FAIL mul_busy: ready_low=%0d early_pulses=%0d want 32/0", busy, pulses);
        end
        checks++;
        if (alu_res_valid !== 1'b1 || alu_res !== 32'h23456780 || alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_result: res=%h valid=%b ready=%b want 23456780/1/1", alu_res, alu_res_valid, alu_ready);
        end
        @(negedge clk);
        alu_valid = 1'b0;
        checks++;
        if (alu_res_valid !== 1'b1 || alu_res !== 32'd5) begin
            failures++;
            $display("FAIL held_add: res=%h valid=%b want 00000005/1", alu_res, alu_res_valid);
        end
        @(negedge clk);
        checks++;
        if (alu_res_valid !== 1'b0) begin
            failures++;
            $display("FAIL mul_single_pulse: valid=%b want 0", alu_res_valid);
        end
    endtask

    task automatic test_div();
        logic [4:0]  ops [4];
        logic [31:0] a_tab [4];
        logic [31:0] b_tab [4];
        logic [31:0] e_tab [4];
        logic [31:0] res;
        int n;
        ops   = '{5'd14, 5'd15, 5'd14, 5'd15};
        a_tab = '{32'd100, 32'd100, 32'hFFFFFFFF, 32'h00001234};
        b_tab = '{32'd7, 32'd7, 32'd0, 32'd0};
        e_tab = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'h00001234};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], a_tab[i], b_tab[i], res, n);
            checks++;
            if (res !== e_tab[i] || n != 33) begin
                failures++;
                $display("FAIL div_case%0d: res=%h lat=%0d want %h/33", i, res, n, e_tab[i]);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        int pulses = 0;
        logic [31:0] res;
        int n;
        alu_valid = 1'b1; alu_op = 5'd14; alu_src0 = 32'd1000; alu_src1 = 32'd3;
        @(negedge clk);
        alu_valid = 1'b0;
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || alu_res !== 32'd0 || alu_res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_div: ready=%b res=%h valid=%b want 1/00000000/0", alu_ready, alu_res, alu_res_valid);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (alu_res_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL aborted_div_pulse: pulses=%0d want 0", pulses);
        end
        run_op(5'd0, 32'd2, 32'd3, res, n);
        checks++;
        if (res !== 32'd5 || n != 1) begin
            failures++;
            $display("FAIL add_after_reset: res=%h lat=%0d want 00000005/1", res, n);
        end
    endtask

    task automatic test_reserved();
        logic [31:0] res;
        int n;
        run_op(5'd0, 32'd40, 32'd2, res, n);
        run_op(5'd31, 32'h12345678, 32'h9ABCDEF0, res, n);
        checks++;
        if (res !== 32'd0 || n != 1) begin
            failures++;
            $display("FAIL reserved_op31: res=%h lat=%0d want 00000000/1", res, n);
        end
    endtask

    task automatic test_signed_div();
        logic [31:0] res;
        int n;
`ifdef SEQ_ALU_SIGNED_DIV_EN
        logic [4:0]  ops [4];
        logic [31:0] a_tab [4];
        logic [31:0] b_tab [4];
        logic [31:0] e_tab [4];
        ops   = '{5'd16, 5'd17, 5'd16, 5'd17};
        a_tab = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
        b_tab = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
        e_tab = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], a_tab[i], b_tab[i], res, n);
            checks++;
            if (res !== e_tab[i] || n != 33) begin
                failures++;
                $display("FAIL sdiv_case%0d: res=%h lat=%0d want %h/33", i, res, n, e_tab[i]);
            end
        end
`else
        run_op(5'd0, 32'd7, 32'd1, res, n);
        run_op(5'd16, 32'd100, 32'd7, res, n);
        checks++;
        if (res !== 32'd0 || n != 1) begin
            failures++;
            $display("FAIL op16_reserved: res=%h lat=%0d want 00000000/1", res, n);
        end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_sweep();
        test_mul_busy();
        test_div();
        test_reset_mid_div();
        test_reserved();
        test_signed_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the combinational ALU.
- Keeps the 5-bit op interface and single-cycle logic/arith/shift ops, now registered with one-cycle latency.
- Adds iterative multiply and unsigned divide/remainder, each taking WIDTH cycles.
- Sits in the execute stage; the pipeline stalls while alu_ready is low.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of two); shift amount uses src1[$clog2(WIDTH)-1:0]

Ports:
clk  in  1  clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
alu_valid  in  1  request strobe; accepted when alu_valid && alu_ready at a clock edge
alu_ready  out  1  high when idle (state IDLE), combinational from state
alu_op  in  5  operation select, sampled on accept
alu_src0  in  WIDTH  operand 0, sampled on accept
alu_src1  in  WIDTH  operand 1, sampled on accept
alu_res  out  WIDTH  result register; holds the last result until the next completion
alu_res_valid  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rstn low):
  - state=IDLE, alu_res=0, alu_res_valid=0, alu_ready=1.
  - Counters and operand registers cleared.
  - Reset mid-operation aborts it; no alu_res_valid pulse is produced.
- Op encoding:
  - 0 ADD, 1 SUB, 2 SLT (signed, result 0/1), 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLL, 9 SRL, 10 SRA, 11 SRC0 (pass src0), 12 SRC1 (pass src1).
  - 13 MUL (low WIDTH bits of product), 14 DIVU, 15 REMU.
  - 16-31 reserved: treated as single-cycle, result 0.
  - ADD/SUB wrap modulo 2^WIDTH; no flags.
- FSM states: IDLE, MUL, DIV.
  - IDLE + accept of a single-cycle op: alu_res and alu_res_valid load at the accept edge, so result visible the next cycle. Stays IDLE; back-to-back accepts, one per cycle.
  - IDLE + accept of op 13 -> MUL; op 14/15 -> DIV. Operands latched, counter=0, alu_res_valid=0.
  - MUL: shift-add, one src1 bit per cycle, LSB first.
  - DIV: restoring division, one quotient bit per cycle, MSB first.
  - Each iterative state does WIDTH iterations at edges k+1..k+WIDTH (k = accept edge). Edge k+WIDTH writes alu_res, pulses alu_res_valid and returns to IDLE.
  - Next accept possible at edge k+WIDTH+1.
- alu_valid while alu_ready=0 is ignored: no queuing, no effect on the current operation.
- alu_res_valid is high for exactly one cycle per completed request; low otherwise.
- Division by zero:
  - DIVU returns all ones; REMU returns src0.
  - Full WIDTH-cycle latency applies; no exception.
- Operand inputs may change after the accept edge without affecting the result.

Optional Feature:
SEQ_ALU_SIGNED_DIV_EN
- Defined: op 16 DIV (signed) and op 17 REM (signed) use the DIV state.
  - Operands are converted to magnitudes, divided unsigned, then signs fixed: quotient negative iff operand signs differ; remainder takes the sign of src0.
  - Same WIDTH-cycle latency.
  - Divide by zero: quotient all ones, remainder src0.
  - Most-negative / -1: quotient = most-negative, remainder 0.
- Undefined: ops 16/17 are reserved, i.e. single-cycle with result 0.

Test Plan (WIDTH=32):
- Sweep ops 0-12 with src0=0x8000FFFF, src1=0x1, one accept per cycle:
  - ADD 0x80010000, SUB 0x8000FFFE, SLT 1, SLTU 0, SLL 0x0001FFFE, SRL 0x40007FFF, SRA 0xC0007FFF, NOR 0x7FFF0000.
  - alu_res_valid pulses the cycle after each accept; alu_ready stays 1.
- MUL 0x12345678 x 0x10 -> alu_res=0x23456780.
  - alu_ready low for 32 cycles; alu_res_valid exactly once, 32 cycles after accept.
  - alu_valid with op ADD held high throughout busy is ignored, and accepted immediately once alu_ready returns.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0xFFFFFFFF/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
- Reset: assert rstn low 10 cycles into a DIVU.
  - Immediately alu_ready=1, alu_res=0, no alu_res_valid pulse.
  - A following ADD 2+3 returns 5.
- Reserved op 31 -> alu_res=0, one-cycle latency.
- With SEQ_ALU_SIGNED_DIV_EN:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Without SEQ_ALU_SIGNED_DIV_EN: op 16 -> 0, one-cycle latency.
